// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - E-stage forwarding selects, load-use stall counter and branch flush control
// Optional: `define ZERO_REG_HARDWIRED_EN makes register 0 never match for forwarding or load-use.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int MEM_LAT    = 2,
    parameter int CNT_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] srcD,
    input  logic [NUM_SRC-1:0]            srcValidD,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] srcE,
    input  logic [NUM_SRC-1:0]            srcValidE,
    input  logic [REG_ADDR_W-1:0]         destE,
    input  logic                          memReadE,
    input  logic [REG_ADDR_W-1:0]         destM,
    input  logic                          regWriteM,
    input  logic [REG_ADDR_W-1:0]         destW,
    input  logic                          regWriteW,
    input  logic                          branchTaken,
    output logic                          stallF,
    output logic                          stallD,
    output logic                          flushF,
    output logic                          flushD,
    output logic                          flushE,
    output logic [2*NUM_SRC-1:0]          fwdSel,
    output logic [CNT_W-1:0]              stallCnt
);

    typedef enum logic {S_IDLE, S_STALL} state_t;

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [2*NUM_SRC-1:0] w_fwd;
    logic               w_lu_any;
    logic               w_lu_hit;
    logic               w_stall;

    function automatic logic addr_eq(input logic [REG_ADDR_W-1:0] a,
                                     input logic [REG_ADDR_W-1:0] b);
`ifdef ZERO_REG_HARDWIRED_EN
        return (a == b) && (a != '0);
`else
        return a == b;
`endif
    endfunction

    // M result is younger than W, so it wins when both write the same register
    always_comb begin
        w_fwd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (srcValidE[k] && regWriteM && addr_eq(destM, srcE[k*REG_ADDR_W +: REG_ADDR_W]))
                w_fwd[2*k +: 2] = 2'b10;
            else if (srcValidE[k] && regWriteW && addr_eq(destW, srcE[k*REG_ADDR_W +: REG_ADDR_W]))
                w_fwd[2*k +: 2] = 2'b01;
        end
    end

    always_comb begin
        w_lu_any = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (srcValidD[k] && addr_eq(srcD[k*REG_ADDR_W +: REG_ADDR_W], destE))
                w_lu_any = 1'b1;
        end
        w_lu_hit = memReadE && w_lu_any && !branchTaken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Detect cycle is the first stall cycle; STALL covers the remaining MEM_LAT-1
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_cnt = '0;
                if (w_lu_hit) begin
                    w_stall = 1'b1;
                    if (MEM_LAT > 1) begin
                        w_next_state = S_STALL;
                        w_next_cnt   = LOAD_VAL;
                    end
                end
            end
            S_STALL: begin
                if (branchTaken) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign stallF   = w_stall && !rst;
    assign stallD   = w_stall && !rst;
    assign flushE   = w_stall && !rst;
    assign flushF   = branchTaken && !rst;
    assign flushD   = branchTaken && !rst;
    assign fwdSel   = rst ? '0 : w_fwd;
    assign stallCnt = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - checks three MEM_LAT variants (1,2,3) against a remaining-cycles model
module tb_hazard_ctrl_unit;

`ifdef ZERO_REG_HARDWIRED_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] srcD, srcE;
    logic [1:0] srcValidD, srcValidE;
    logic [3:0] destE, destM, destW;
    logic       memReadE, regWriteM, regWriteW, branchTaken;

    logic       stallF_a [3];
    logic       stallD_a [3];
    logic       flushF_a [3];
    logic       flushD_a [3];
    logic       flushE_a [3];
    logic [3:0] fwdSel_a [3];
    logic [3:0] stallCnt_a [3];

    int errors = 0;
    int checks = 0;
    int rem [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl_unit #(.REG_ADDR_W(4), .NUM_SRC(2), .MEM_LAT(g + 1), .CNT_W(4)) u_dut (
            .clk(clk), .rst(rst),
            .srcD(srcD), .srcValidD(srcValidD), .srcE(srcE), .srcValidE(srcValidE),
            .destE(destE), .memReadE(memReadE), .destM(destM), .regWriteM(regWriteM),
            .destW(destW), .regWriteW(regWriteW), .branchTaken(branchTaken),
            .stallF(stallF_a[g]), .stallD(stallD_a[g]), .flushF(flushF_a[g]),
            .flushD(flushD_a[g]), .flushE(flushE_a[g]), .fwdSel(fwdSel_a[g]),
            .stallCnt(stallCnt_a[g])
        );
    end

    typedef struct {
        logic [7:0] s_srcE;
        logic [1:0] s_valE;
        logic [3:0] s_destM;
        logic       s_wrM;
        logic [3:0] s_destW;
        logic       s_wrW;
        logic [3:0] exp_fwd;
    } fwd_vec_t;

    fwd_vec_t vecs [7];

    function automatic bit reg_match(input logic [3:0] a, input logic [3:0] b);
        return (a == b) && !(ZR && a == 4'd0);
    endfunction

    function automatic logic [3:0] model_fwd();
        logic [3:0] f = 4'd0;
        for (int k = 0; k < 2; k++) begin
            logic [3:0] s = srcE[4*k +: 4];
            if (srcValidE[k] && regWriteM && reg_match(destM, s)) f[2*k +: 2] = 2'b10;
            else if (srcValidE[k] && regWriteW && reg_match(destW, s)) f[2*k +: 2] = 2'b01;
        end
        return rst ? 4'd0 : f;
    endfunction

    function automatic bit model_lu();
        bit any = 1'b0;
        for (int k = 0; k < 2; k++)
            if (srcValidD[k] && reg_match(srcD[4*k +: 4], destE)) any = 1'b1;
        return memReadE && any && !branchTaken;
    endfunction

    task automatic check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d", name, d, act, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            bit s = rst ? 1'b0 : (rem[d] > 0 ? !branchTaken : model_lu());
            bit b = rst ? 1'b0 : branchTaken;
            check("fwdSel", d, fwdSel_a[d], model_fwd());
            check("ctrl", d, {stallF_a[d], stallD_a[d], flushE_a[d], flushF_a[d], flushD_a[d]},
                  {s, s, s, b, b});
            check("stallCnt", d, stallCnt_a[d], rst ? 0 : rem[d]);
        end
    endtask

    task automatic model_edge();
        bit lu = model_lu();
        for (int d = 0; d < 3; d++) begin
            if (rst || branchTaken) rem[d] = 0;
            else if (rem[d] > 0) rem[d] = rem[d] - 1;
            else if (lu) rem[d] = d;
        end
    endtask

    task automatic step();
        #3;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_in();
        srcD = 8'h00; srcE = 8'h00; srcValidD = 2'b00; srcValidE = 2'b00;
        destE = 4'd0; destM = 4'd0; destW = 4'd0;
        memReadE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0; branchTaken = 1'b0;
    endtask

    task automatic load_use(input logic [3:0] r);
        memReadE = 1'b1; destE = r; srcD = {4'd9, r}; srcValidD = 2'b01;
    endtask

    int stl [3][4];
    int cnt [3][4];
    int fl  [3][3];

    initial begin
        vecs[0] = '{8'h03, 2'b01, 4'd3, 1'b1, 4'd0, 1'b0, 4'b0010};
        vecs[1] = '{8'h52, 2'b11, 4'd5, 1'b1, 4'd5, 1'b1, 4'b1000};
        vecs[2] = '{8'h02, 2'b01, 4'd9, 1'b0, 4'd2, 1'b1, 4'b0001};
        vecs[3] = '{8'h03, 2'b00, 4'd3, 1'b1, 4'd3, 1'b1, 4'b0000};
        vecs[4] = '{8'h44, 2'b11, 4'd4, 1'b0, 4'd4, 1'b1, 4'b0101};
        vecs[5] = '{8'h61, 2'b11, 4'd1, 1'b1, 4'd6, 1'b1, 4'b0110};
        vecs[6] = '{8'h00, 2'b01, 4'd0, 1'b1, 4'd7, 1'b0, ZR ? 4'b0000 : 4'b0010};

        for (int d = 0; d < 3; d++) rem[d] = 0;
        clear_in();
        rst = 1'b1;
        srcE = 8'h03; srcValidE = 2'b01; destM = 4'd3; regWriteM = 1'b1; branchTaken = 1'b1;
        #2;
        for (int d = 0; d < 3; d++)
            check("reset_outputs", d,
                  {stallF_a[d], stallD_a[d], flushE_a[d], flushF_a[d], flushD_a[d], fwdSel_a[d], stallCnt_a[d]}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_in();
        step();

        for (int i = 0; i < 7; i++) begin
            clear_in();
            srcE = vecs[i].s_srcE; srcValidE = vecs[i].s_valE;
            destM = vecs[i].s_destM; regWriteM = vecs[i].s_wrM;
            destW = vecs[i].s_destW; regWriteW = vecs[i].s_wrW;
            #3;
            check("fwd_vec", i, fwdSel_a[1], vecs[i].exp_fwd);
            step();
        end

        // load-use: luHit only in detect cycle, stall must carry itself
        stl = '{'{1, 0, 0, 0}, '{1, 1, 0, 0}, '{1, 1, 1, 0}};
        cnt = '{'{0, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 2, 1, 0}};
        clear_in();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) load_use(4'd7); else clear_in();
            #3;
            for (int d = 0; d < 3; d++) begin
                check("lu_stall", d, stallF_a[d], stl[d][c]);
                check("lu_cnt", d, stallCnt_a[d], cnt[d][c]);
            end
            step();
        end

        // branch in the second stall cycle
        stl = '{'{1, 0, 0, 0}, '{1, 0, 0, 0}, '{1, 0, 0, 0}};
        cnt = '{'{0, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 2, 0, 0}};
        fl  = '{'{0, 1, 0}, '{0, 1, 0}, '{0, 1, 0}};
        for (int c = 0; c < 3; c++) begin
            clear_in();
            if (c == 0) load_use(4'd7);
            if (c == 1) branchTaken = 1'b1;
            #3;
            for (int d = 0; d < 3; d++) begin
                check("br_stall", d, stallD_a[d], stl[d][c]);
                check("br_flush", d, {flushF_a[d], flushD_a[d]}, fl[d][c] * 3);
                check("br_cnt", d, stallCnt_a[d], cnt[d][c]);
            end
            step();
        end

        // async reset mid-stall
        clear_in();
        load_use(4'd5);
        step();
        clear_in();
        srcE = 8'h03; srcValidE = 2'b01; destM = 4'd3; regWriteM = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("arst_stall", 2, {stallF_a[2], stallD_a[2], flushE_a[2]}, 0);
        check("arst_cnt", 2, stallCnt_a[2], 0);
        check("arst_fwd", 2, fwdSel_a[2], 0);
        for (int d = 0; d < 3; d++) rem[d] = 0;
        @(posedge clk); #3;
        rst = 1'b0;
        clear_in();
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("post_arst_stall", 2, stallF_a[2], 0);
            step();
        end

        // register 0 load-use
        clear_in();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) load_use(4'd0); else clear_in();
            #1;
            check("zero_reg_stall", 1, stallF_a[1], ZR ? 0 : 1);
            step();
        end
        clear_in();
        step();

        for (int i = 0; i < 400; i++) begin
            srcD = 8'($urandom_range(0, 255)) & 8'h33;
            srcE = 8'($urandom_range(0, 255)) & 8'h33;
            srcValidD = 2'($urandom_range(0, 3));
            srcValidE = 2'($urandom_range(0, 3));
            destE = 4'($urandom_range(0, 3));
            destM = 4'($urandom_range(0, 3));
            destW = 4'($urandom_range(0, 3));
            memReadE = 1'($urandom_range(0, 1));
            regWriteM = 1'($urandom_range(0, 1));
            regWriteW = 1'($urandom_range(0, 1));
            branchTaken = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
